// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo slew front-end.
package servo_pkg;

  localparam int PW_W = 12;

  localparam int DEF_PERIOD   = 4000;
  localparam int DEF_PW_MIN   = 200;
  localparam int DEF_PW_MAX   = 400;
  localparam int DEF_STEP_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAP  = 2'd1,
    SLEW = 2'd2
  } state_t;

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter 0..PERIOD with a tick on the last cycle of each frame.
module frame_timer #(
  parameter int PERIOD = 4000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] frame_cnt;

  assign frame_tick = (frame_cnt == CW'(PERIOD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Maps position commands to a target pulse width and slews the PWM pulse width
// toward it by at most STEP_MAX per frame, changing only on frame boundaries.
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int PW_MIN   = DEF_PW_MIN,
  parameter int PW_MAX   = DEF_PW_MAX,
  parameter int STEP_MAX = DEF_STEP_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cmd_valid,
  input  logic [7:0]      cmd_pos,
  output logic            cmd_ready,
  output logic [PW_W-1:0] period,
  output logic [PW_W-1:0] pulsewidth,
  output logic            frame_tick,
  output logic            busy
);

  localparam int PW_SPAN = PW_MAX - PW_MIN;
  localparam int PROD_W  = PW_W + 8;

  localparam logic [PROD_W-1:0] SPAN_L   = PROD_W'(PW_SPAN);
  localparam logic [PW_W-1:0]   MIN_L    = PW_W'(PW_MIN);
  localparam logic [PW_W-1:0]   CENTER_L = PW_W'(PW_MIN + (PW_SPAN >> 1));
  localparam logic [PW_W-1:0]   STEP_L   = PW_W'(STEP_MAX);

  // Handshake: a command transfers on any rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on state, never on cmd_valid.

  state_t            state;
  logic [7:0]        pos_q;
  logic [PW_W-1:0]   target;
  logic [PROD_W-1:0] prod;
  logic [PW_W-1:0]   map_pw;
  logic [PW_W-1:0]   diff;
  logic [PW_W-1:0]   step;
  logic              accept;
  logic              do_step;

  frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign period    = PW_W'(PERIOD);
  assign cmd_ready = (state != MAP);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Full-width product then drop the /256 bits; 255 stays one LSB-ish short of PW_MAX.
  assign prod   = {{PW_W{1'b0}}, pos_q} * SPAN_L;
  assign map_pw = MIN_L + PW_W'(prod >> 8);

  always_comb begin
    diff = '0;
    step = '0;
    if (target >= pulsewidth) diff = target - pulsewidth;
    else                      diff = pulsewidth - target;
    step = (diff < STEP_L) ? diff : STEP_L;
  end

  assign do_step = (state == SLEW) & frame_tick & en & (diff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos_q      <= '0;
      target     <= CENTER_L;
      pulsewidth <= CENTER_L;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pos_q <= cmd_pos;
            state <= MAP;
          end
        end
        MAP: begin
          target <= map_pw;
          state  <= SLEW;
        end
        SLEW: begin
          // The step always uses the target already held; a retarget only
          // takes effect after the following MAP cycle.
          if (do_step) begin
            if (target > pulsewidth) pulsewidth <= pulsewidth + step;
            else                     pulsewidth <= pulsewidth - step;
          end
          if (accept) begin
            pos_q <= cmd_pos;
            state <= MAP;
          end else if (pulsewidth == target) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/servo_slew_ctrl.md
# servo_slew_ctrl

Servo position front-end that sits directly upstream of the `pwm` stage. It accepts 8-bit position commands over a valid/ready handshake and maps each one to a target pulse width. It then slews its `pulsewidth` output toward that target by a bounded step once per PWM frame. Updates land only on frame boundaries, so the downstream PWM never sees a mid-frame pulse-width change.

## Interface
Parameters:
- `PERIOD`, 4000: frame length minus one, in clk cycles. Drives the `period` output.
- `PW_MIN`, 200: pulse width for position 0, in cycles.
- `PW_MAX`, 400: upper pulse-width bound. Legal only if PW_MIN < PW_MAX ≤ PERIOD.
- `STEP_MAX`, 4: maximum pulse-width change per frame. Must be ≥ 1.

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  slew enable; when low, `pulsewidth` is frozen.
- `cmd_valid`  in  1  position command valid.
- `cmd_pos`  in  8  commanded position, 0..255.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `period`  out  12  constant PERIOD, to downstream PWM.
- `pulsewidth`  out  12  current slewed pulse width, to downstream PWM.
- `frame_tick`  out  1  one-cycle pulse on the last cycle of each frame.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- SPAN = PW_MAX − PW_MIN. CENTER = PW_MIN + (SPAN >> 1).
- Mapping: target = PW_MIN + ((cmd_pos × SPAN) >> 8). Compute at full product width, then truncate to 12 bits.
  - Position 255 maps to PW_MIN + floor(255·SPAN/256), never to PW_MAX itself.
- Frame counter `frame_cnt` counts 0..PERIOD, then wraps to 0. It is free-running and unaffected by `en`.
- `frame_tick` = (frame_cnt == PERIOD). This keeps the block in lockstep with a PWM counter released from reset on the same edge.
- FSM states:
  - IDLE: `cmd_ready` = 1. On accept, go to MAP.
  - MAP: one cycle. `cmd_ready` = 0. Register `target` from the captured `cmd_pos`, then go to SLEW.
  - SLEW: `cmd_ready` = 1. On `frame_tick & en`:
    - step = min(STEP_MAX, |target − pulsewidth|);
    - pulsewidth moves toward target by step.
  - Leave SLEW for IDLE on the cycle after `pulsewidth == target`, including the case where they are equal on entry.
  - A new accept while in SLEW goes to MAP (retarget).
- Simultaneous events:
  - Accept and `frame_tick` in the same SLEW cycle: the step is applied using the old target, then the FSM goes to MAP.
  - `frame_tick` while in MAP: no step that frame.
- `en` low: no steps, commands still accepted, FSM still advances through MAP.
- Reset values:
  - pulsewidth = CENTER, target = CENTER
  - frame_cnt = 0, state = IDLE
  - cmd_ready = 1, busy = 0, frame_tick = 0
  - period = PERIOD at all times
- Reset asserted mid-slew forces all reset values immediately, with no clock edge needed. The in-flight command is lost.

## Timing
- Command to target registered: 2 edges (accept edge, then MAP edge).
- First possible `pulsewidth` change: the first `frame_tick` edge after entering SLEW.
- `pulsewidth` changes only on an edge where `frame_tick` = 1. The new value is valid from frame_cnt = 0 of the next frame.
- Slew time from |Δ| = D: ceil(D / STEP_MAX) frames.
- All outputs are registered except `cmd_ready`, `busy` and `frame_tick`, which decode registered state.

## Structure
- Package `servo_pkg` holds:
  - the FSM state enum (IDLE, MAP, SLEW);
  - default PERIOD, PW_MIN, PW_MAX and STEP_MAX constants;
  - a `PW_W = 12` width constant.
- Sub-module `frame_timer` holds the counter and tick generation (parameter PERIOD; ports clk, rst_n, frame_tick).
- The mapping multiply, the step clamp and the FSM stay in the top module.

## Test plan
Bench parameters: PERIOD = 499, PW_MIN = 200, PW_MAX = 400, STEP_MAX = 4.
- Reset release → pulsewidth = 300, period = 499, cmd_ready = 1, busy = 0; first `frame_tick` on the 500th cycle, then every 500 cycles.
- cmd_pos = 255 → target 399; pulsewidth goes 304, 308 … 396, 399 on 25 consecutive ticks; busy falls 1 cycle after 399 appears.
- cmd_pos = 0 from reset → 296 … 200 over 25 ticks; cmd_pos = 128 afterwards → 300 after 25 ticks.
- Retarget: cmd_pos = 255, then cmd_pos = 128 after 5 ticks (pulsewidth 320) → pulsewidth 316 … 300 over 5 ticks, then IDLE.
- `en` low for 3 ticks mid-slew → pulsewidth held, `frame_tick` still pulses; slew resumes on the next tick after `en` rises.
- rst_n driven low between clock edges during SLEW → pulsewidth = 300, busy = 0, cmd_ready = 1 immediately; frame_cnt restarts from 0.
